// File: rtl/button_debounce.sv
// Three-channel push-button conditioner: synchronizer, debounce filter,
// press/release edge pulses and a one-shot long-press pulse per channel.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_in,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release,
  output logic [2:0] btn_long
);

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 32;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             level;
    logic             press;
    logic             rel;
    logic             lng;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             mismatch_c;
    logic             accept_c;

    assign mismatch_c = (s2 != level);
    // A level change is accepted on the last of DEBOUNCE_CYCLES mismatch cycles.
    assign accept_c   = mismatch_c && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        level    <= 1'b0;
        press    <= 1'b0;
        rel      <= 1'b0;
        lng      <= 1'b0;
        db_cnt   <= '0;
        hold_cnt <= '0;
      end else begin
        s1 <= btn_in[ch];
        s2 <= s1;

        if (!mismatch_c || accept_c) begin
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end

        if (accept_c) begin
          level <= ~level;
        end
        press <= accept_c && !level;
        rel   <= accept_c && level;

        // Hold counter saturates so the long pulse fires once per press.
        if (!level) begin
          hold_cnt <= '0;
        end else if (hold_cnt != LONG_MAX) begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end
        lng <= level && (hold_cnt == LONG_LAST);
      end
    end

    assign btn_level[ch]   = level;
    assign btn_press[ch]   = press;
    assign btn_release[ch] = rel;
    assign btn_long[ch]    = lng;
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: table of press scenarios with an event
// scoreboard, plus bounce and reset-during-debounce sequences.
module tb_button_debounce;
  localparam int unsigned DB = 4;
  localparam int unsigned LG = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_in;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic [2:0] btn_long;

  button_debounce #(.DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] lng;
    logic [2:0] level;
  } ev_t;

  // mask held on btn_in for 'hold' cycles; p/r/l = edge count (from drive)
  // after which press/release/long is expected, -1 = never.
  typedef struct {
    logic [2:0] mask;
    int         hold;
    int         p;
    int         r;
    int         l;
  } vec_t;

  ev_t  exp_q[$];
  ev_t  got;
  vec_t tbl[7];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   start;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every nonzero pulse vector must match the next expected event.
  always @(negedge clk) begin
    if ((btn_press | btn_release | btn_long) != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cyc=%0d press=%b release=%b long=%b, required no pulse",
                 cyc, btn_press, btn_release, btn_long);
      end else begin
        got = exp_q.pop_front();
        if (cyc != got.cyc || btn_press != got.press || btn_release != got.rel ||
            btn_long != got.lng || btn_level != got.level) begin
          errors++;
          $display("FAIL event: got cyc=%0d press=%b release=%b long=%b level=%b, required cyc=%0d press=%b release=%b long=%b level=%b",
                   cyc, btn_press, btn_release, btn_long, btn_level,
                   got.cyc, got.press, got.rel, got.lng, got.level);
        end
      end
    end
  end

  task automatic push(input int c, input logic [2:0] p, input logic [2:0] r,
                      input logic [2:0] l, input logic [2:0] lv);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.level = lv;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{3'b001, 12,  6, 18, 16};
    tbl[1] = '{3'b010,  3, -1, -1, -1};
    tbl[2] = '{3'b100, 30,  6, 36, 16};
    tbl[3] = '{3'b001,  8,  6, 14, -1};
    tbl[4] = '{3'b111,  5,  6, 11, -1};
    tbl[5] = '{3'b010,  4,  6, 10, -1};
    tbl[6] = '{3'b110,  2, -1, -1, -1};

    rst    = 1'b1;
    btn_in = 3'b000;
    #1;
    chk("reset_outputs", {btn_level, btn_press, btn_release, btn_long}, 12'h000);
    tick(3);
    chk("reset_held", {btn_level, btn_press, btn_release, btn_long}, 12'h000);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 7; i++) begin
      start  = cyc;
      btn_in = tbl[i].mask;
      if (tbl[i].p >= 0) push(start + tbl[i].p, tbl[i].mask, 3'b000, 3'b000, tbl[i].mask);
      if (tbl[i].l >= 0) push(start + tbl[i].l, 3'b000, 3'b000, tbl[i].mask, tbl[i].mask);
      if (tbl[i].r >= 0) push(start + tbl[i].r, 3'b000, tbl[i].mask, 3'b000, 3'b000);
      tick(tbl[i].hold);
      btn_in = 3'b000;
      tick(20);
      chk_drained($sformatf("vec%0d_events", i));
      chk($sformatf("vec%0d_level_idle", i), {9'b0, btn_level}, 12'h000);
    end

    // Bounce: 3-cycle high bursts never reach the 4-cycle threshold.
    for (int rep = 0; rep < 10; rep++) begin
      for (int k = 0; k < 4; k++) begin
        btn_in = (k < 3) ? 3'b010 : 3'b000;
        tick(1);
        chk("bounce_level", {9'b0, btn_level}, 12'h000);
      end
    end
    btn_in = 3'b000;
    tick(10);

    // Reset while ch0 is pressed and ch1/ch2 are mid-debounce.
    start  = cyc;
    btn_in = 3'b001;
    push(start + 6, 3'b001, 3'b000, 3'b000, 3'b001);
    tick(6);
    chk("pre_reset_level", {9'b0, btn_level}, 12'h001);
    btn_in = 3'b111;
    tick(4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {btn_level, btn_press, btn_release, btn_long}, 12'h000);
    tick(3);
    chk("reset_hold_outputs", {btn_level, btn_press, btn_release, btn_long}, 12'h000);
    rst   = 1'b0;
    start = cyc;
    push(start + 6,  3'b111, 3'b000, 3'b000, 3'b111);
    push(start + 12, 3'b000, 3'b111, 3'b000, 3'b000);
    tick(5);
    chk("post_reset_level_k5", {9'b0, btn_level}, 12'h000);
    tick(1);
    chk("post_reset_level_k6", {9'b0, btn_level}, 12'h007);
    btn_in = 3'b000;
    tick(14);
    chk_drained("reset_seq_events");
    chk("reset_seq_level_idle", {9'b0, btn_level}, 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
